// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-rate divider: one-cycle bit_tick every CLKS_PER_BIT cycles, restarted by clear.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_tick = (cnt_q == LAST_CNT) && !clear;
    cnt_d    = cnt_q + 1'b1;
    if (clear || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single 8N1 UART transmitter on TXD.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  input  logic [7:0] REQ0_DATA,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [7:0] REQ1_DATA,
  output logic       REQ1_READY,
  output logic       TXD,
  output logic       BUSY,
  output logic       GRANT_ID
);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic [BIT_IDX_W-1:0] bit_idx_d;
  logic                 txd_q;
  logic                 busy_q;
  logic                 grant_q;
  logic                 last_grant_q;
  logic                 grant_d;
  logic                 accept;
  logic                 timer_clear;
  logic                 bit_tick;

  // With both requesters valid the one that did not win last time goes next.
  always_comb begin
    grant_d = REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) begin
      grant_d = ~last_grant_q;
    end
    accept      = (state_q == ST_IDLE) && !RESET && (REQ0_VALID || REQ1_VALID);
    REQ0_READY  = accept && !grant_d;
    REQ1_READY  = accept && grant_d;
    bit_idx_d   = bit_idx_q + 1'b1;
    timer_clear = (state_q == ST_IDLE);
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (timer_clear),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      txd_q        <= IDLE_LEVEL;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_q      <= grant_d ? REQ1_DATA : REQ0_DATA;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= ST_START;
            txd_q        <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == LAST_BIT_IDX) begin
              state_q <= ST_STOP;
              txd_q   <= IDLE_LEVEL;
            end else begin
              bit_idx_q <= bit_idx_d;
              txd_q     <= shift_q[bit_idx_d];
            end
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TXD      = txd_q;
  assign BUSY     = busy_q;
  assign GRANT_ID = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: table-driven single frames plus contention, reset, withdrawal and default-baud sequences.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, v1, r0, r1, txd, busy, gid;
  logic [7:0] d0, d1;
  logic       b_v0, b_v1, b_r0, b_r1, b_txd, b_busy, b_gid;
  logic [7:0] b_d0, b_d1;

  uart_tx_arbiter #(.CLKS_PER_BIT(4)) dut_a (
    .CLK(clk), .RESET(rst),
    .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_READY(r0),
    .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_READY(r1),
    .TXD(txd), .BUSY(busy), .GRANT_ID(gid)
  );

  uart_tx_arbiter dut_b (
    .CLK(clk), .RESET(rst),
    .REQ0_VALID(b_v0), .REQ0_DATA(b_d0), .REQ0_READY(b_r0),
    .REQ1_VALID(b_v1), .REQ1_DATA(b_d1), .REQ1_READY(b_r1),
    .TXD(b_txd), .BUSY(b_busy), .GRANT_ID(b_gid)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       eg;
    logic [9:0] ef;   // expected TXD levels, index = bit slot (0 = start)
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for a READY, then steps through the accept edge.
  task automatic accept(input bit big, output int who, output time t_acc);
    int   budget;
    logic rr0, rr1;
    budget = big ? 3000 : 200;
    who    = -1;
    rr0    = 1'b0;
    rr1    = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #1;
      rr0 = big ? b_r0 : r0;
      rr1 = big ? b_r1 : r1;
      if (rr0 || rr1) begin
        who = rr1 ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (who < 0) begin
      errors++;
      $display("FAIL accept_timeout: got no READY within %0d cycles", budget);
    end else if (rr0 && rr1) begin
      errors++;
      $display("FAIL ready_onehot: got READY0=1 READY1=1 expected at most one");
    end
    @(posedge clk);
    t_acc = $time;
    $display("accept req%0d at %0t", who, $time);
  endtask

  task automatic frame_check(input string nm, input logic [9:0] expf, input logic eg, input bit big);
    int n;
    int bad;
    n = big ? 104 : 4;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if ((big ? b_txd : txd) !== expf[b]) bad++;
        if ((big ? b_busy : busy) !== 1'b1) bad++;
        if ((big ? (b_r0 | b_r1) : (r0 | r1)) !== 1'b0) bad++;
      end
      chk($sformatf("%s_bit%0d_badcycles", nm, b), bad, 0);
    end
    chk($sformatf("%s_grant", nm), big ? b_gid : gid, eg);
    @(negedge clk);
    chk($sformatf("%s_end_busy", nm), big ? b_busy : busy, 0);
    chk($sformatf("%s_end_txd", nm), big ? b_txd : txd, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  who;
    time t, tprev;
    int  bad;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 10'b1101001010};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 10'b1001111000};
    vecs[2] = '{1'b1, 1'b1, 8'h81, 8'h7E, 1'b0, 10'b1100000010};
    vecs[3] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, 10'b1111100000};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 10'b1000000000};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h12, 1'b0, 10'b1111111110};

    rst = 1'b1;
    v0 = 0; v1 = 0; d0 = 0; d1 = 0;
    b_v0 = 0; b_v1 = 0; b_d0 = 0; b_d1 = 0;

    // Reset state, and RESET beats VALID.
    @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_gid", gid, 0);
    v0 = 1'b1;
    #1;
    chk("reset_ready0", r0, 0);
    v0 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Single frames from the table.
    for (int i = 0; i < 6; i++) begin
      v0 = vecs[i].v0; v1 = vecs[i].v1; d0 = vecs[i].d0; d1 = vecs[i].d1;
      accept(1'b0, who, t);
      chk($sformatf("vec%0d_accept", i), who, vecs[i].eg);
      #1;
      v0 = 1'b0; v1 = 1'b0; d0 = ~d0; d1 = ~d1;
      frame_check($sformatf("vec%0d", i), vecs[i].ef, vecs[i].eg, 1'b0);
    end

    // Contention: strict alternation starting at 0, 41-cycle period.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      accept(1'b0, who, t);
      chk($sformatf("contend%0d_order", k), who, k % 2);
      if (k > 0) chk($sformatf("contend%0d_period", k), 32'((t - tprev) / 10), 41);
      tprev = t;
      frame_check($sformatf("contend%0d", k), (k % 2 == 1) ? 10'b1001000100 : 10'b1000100010,
                  logic'(k % 2), 1'b0);
    end
    v0 = 1'b0; v1 = 1'b0;

    // Lone requester 1 is never starved.
    @(negedge clk);
    v1 = 1'b1; d1 = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      accept(1'b0, who, t);
      chk($sformatf("single%0d_grant", k), who, 1);
      if (k > 0) chk($sformatf("single%0d_period", k), 32'((t - tprev) / 10), 41);
      tprev = t;
      frame_check($sformatf("single%0d", k), 10'b1110000110, 1'b1, 1'b0);
    end
    v1 = 1'b0;

    // Reset during DATA bit 3 of a 8'h00 frame.
    @(negedge clk);
    v0 = 1'b1; d0 = 8'h00;
    accept(1'b0, who, t);
    chk("rstmid_first_grant", who, 0);
    #1 v0 = 1'b0;
    repeat (18) @(negedge clk);
    chk("rstmid_pre_txd", txd, 0);
    chk("rstmid_pre_busy", busy, 1);
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h5A; d1 = 8'hC3;
    @(negedge clk);
    chk("rstmid_txd", txd, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_gid", gid, 0);
    chk("rstmid_ready0", r0, 0);
    chk("rstmid_ready1", r1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rstmid_no_accept", busy, 0);
    accept(1'b0, who, t);
    chk("rstmid_next_grant", who, 0);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    frame_check("rstmid_frame", 10'b1010110100, 1'b0, 1'b0);

    // REQ1_VALID only while BUSY: never accepted.
    v0 = 1'b1; d0 = 8'h99;
    accept(1'b0, who, t);
    chk("withdraw_grant", who, 0);
    #1;
    v0 = 1'b0; v1 = 1'b1; d1 = 8'hEE;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (r0 !== 1'b0 || r1 !== 1'b0) bad++;
      if (i == 39) v1 = 1'b0;
    end
    chk("withdraw_busy_ready", bad, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || r1 !== 1'b0) bad++;
    end
    chk("withdraw_idle", bad, 0);

    // Default divider: 104 cycles per bit.
    b_v0 = 1'b1; b_d0 = 8'h55;
    accept(1'b1, who, t);
    chk("baud104_grant", who, 0);
    #1 b_v0 = 1'b0;
    frame_check("baud104", 10'b1010101010, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
